// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// I/O ring supply sequencer: ascending power-up gated on power-good plus settle,
// descending power-down, sticky fault on power-good loss or ramp timeout.
//
// Ports:
//   clk        sequencer clock
//   rst        synchronous active-high reset
//   en         request ring up (1) or down (0)
//   clr        fault clear, honoured only while en is low
//   pg         per-segment power-good (asynchronous)
//   settle     settle cycles after pg, also the power-down step delay
//   timeout    max ramp cycles, 0 disables
//   seg_en     segment enables
//   ready      all segments up and settled
//   busy       ramping, settling or powering down
//   fault      sticky fault flag
//   fault_seg  index of the faulting segment
//   state      OFF=0 RAMP=1 SETTLE=2 ON=3 DOWN=4 FAULT=5
module gf180mcu_ocd_io__pwr_seq #(
    parameter int NSEG  = 4,
    parameter int CNT_W = 16,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [NSEG-1:0]  pg,
    input  logic [CNT_W-1:0] settle,
    input  logic [CNT_W-1:0] timeout,
    output logic [NSEG-1:0]  seg_en,
    output logic             ready,
    output logic             busy,
    output logic             fault,
    output logic [IDX_W-1:0] fault_seg,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_RAMP   = 3'd1,
        S_SETTLE = 3'd2,
        S_ON     = 3'd3,
        S_DOWN   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           st_q, st_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NSEG-1:0]  seg_q, seg_d;
    logic             flt_q, flt_d;
    logic [IDX_W-1:0] fseg_q, fseg_d;

    logic [NSEG-1:0]  pg_m, pg_s;
    logic [NSEG-1:0]  chk;
    logic             loss;
    logic [IDX_W-1:0] loss_idx;
    logic             pg_cur;
    logic             go_flt;
    logic [IDX_W-1:0] go_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            pg_m <= '0;
            pg_s <= '0;
        end else begin
            pg_m <= pg;
            pg_s <= pg_m;
        end
    end

    // Enabled segments whose power-good is missing. While ramping, the
    // segment being brought up has not reached power-good yet, so skip it.
    always_comb begin
        chk    = seg_q & ~pg_s;
        pg_cur = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pg_cur = pg_s[i];
                if (st_q == S_RAMP) chk[i] = 1'b0;
            end
        end
        loss_idx = '0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (chk[i]) loss_idx = IDX_W'(i);
        end
    end

    assign loss    = |chk;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Segments are enabled strictly in ascending order, so seg_q is always a
    // contiguous run of ones from bit 0: shift left to add the next segment,
    // shift right to drop the highest one.
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        seg_d  = seg_q;
        flt_d  = flt_q;
        fseg_d = fseg_q;
        go_flt = 1'b0;
        go_idx = '0;
        unique case (st_q)
            S_OFF: begin
                if (en) begin
                    st_d  = S_RAMP;
                    seg_d = {{(NSEG-1){1'b0}}, 1'b1};
                    idx_d = '0;
                    cnt_d = '0;
                end
            end
            S_RAMP: begin
                if (loss) begin
                    go_flt = 1'b1;
                    go_idx = loss_idx;
                end else if (!pg_cur && timeout != '0 && cnt_q == timeout) begin
                    go_flt = 1'b1;
                    go_idx = idx_q;
                end else if (!en) begin
                    st_d  = S_DOWN;
                    cnt_d = '0;
                end else if (pg_cur) begin
                    st_d  = S_SETTLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SETTLE: begin
                if (loss) begin
                    go_flt = 1'b1;
                    go_idx = loss_idx;
                end else if (!en) begin
                    st_d  = S_DOWN;
                    cnt_d = '0;
                end else if (cnt_q == settle) begin
                    if (idx_q == IDX_W'(NSEG - 1)) begin
                        st_d = S_ON;
                    end else begin
                        st_d  = S_RAMP;
                        idx_d = idx_q + IDX_W'(1);
                        seg_d = {seg_q[NSEG-2:0], 1'b1};
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ON: begin
                if (loss) begin
                    go_flt = 1'b1;
                    go_idx = loss_idx;
                end else if (!en) begin
                    st_d  = S_DOWN;
                    cnt_d = '0;
                end
            end
            S_DOWN: begin
                if (loss) begin
                    go_flt = 1'b1;
                    go_idx = loss_idx;
                end else if (cnt_q == settle) begin
                    seg_d = seg_q >> 1;
                    cnt_d = '0;
                    if (!seg_q[1]) begin
                        st_d  = S_OFF;
                        idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FAULT: begin
                if (!en && clr) begin
                    st_d   = S_OFF;
                    flt_d  = 1'b0;
                    fseg_d = '0;
                    idx_d  = '0;
                    cnt_d  = '0;
                end
            end
            default: begin
                st_d = S_OFF;
            end
        endcase
        if (go_flt) begin
            st_d   = S_FAULT;
            seg_d  = '0;
            flt_d  = 1'b1;
            fseg_d = go_idx;
            idx_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= S_OFF;
            idx_q  <= '0;
            cnt_q  <= '0;
            seg_q  <= '0;
            flt_q  <= 1'b0;
            fseg_q <= '0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            flt_q  <= flt_d;
            fseg_q <= fseg_d;
        end
    end

    assign seg_en    = seg_q;
    assign fault     = flt_q;
    assign fault_seg = fseg_q;
    assign state     = st_q;
    assign ready     = (st_q == S_ON);
    assign busy      = (st_q == S_RAMP) || (st_q == S_SETTLE) || (st_q == S_DOWN);

endmodule
